// File: rtl/imem_responder.sv
// Instruction-memory responder: single outstanding word fetch with LATENCY wait states,
// flush-cancellable, plus an IDLE-only load port for filling the program array.
//
// state  | meaning
// S_IDLE | accepting loads and fetches
// S_WAIT | fetch accepted, counting down wait states
// S_RESP | response presented, held until consumed or flushed
module imem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_flush,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_inst,
    output logic        o_resp_err,
    input  logic        i_ld_valid,
    output logic        o_ld_ready,
    input  logic [31:0] i_ld_addr,
    input  logic [31:0] i_ld_data
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit          ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0]  CNT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_idx;
    logic            r_pend_err;
    logic [31:0]     r_inst;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH];

    logic [31:0]     w_req_off;
    logic [31:0]     w_ld_off;
    logic            w_req_err;
    logic            w_ld_hit;
    logic [AW-1:0]   w_req_idx;
    logic [AW-1:0]   w_ld_idx;
    logic            w_open;
    logic            w_accept;
    logic            w_ld_we;
    logic            w_enter_resp;

    // Offsets are plain 32-bit differences so an address below the base cannot wrap into range.
    assign w_req_off = i_req_addr - BASE_ADDR;
    assign w_ld_off  = i_ld_addr - BASE_ADDR;
    assign w_req_idx = w_req_off[AW+1:2];
    assign w_ld_idx  = w_ld_off[AW+1:2];
    assign w_req_err = (i_req_addr[1:0] != 2'b00) || (i_req_addr < BASE_ADDR)
                       || ((w_req_off >> 2) >= 32'(DEPTH));
    assign w_ld_hit  = (i_ld_addr >= BASE_ADDR) && ((w_ld_off >> 2) < 32'(DEPTH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_open       = (r_state == S_IDLE) && !i_flush && i_rst_n;
        o_ld_ready   = w_open;
        o_req_ready  = w_open && !i_ld_valid;
        o_resp_valid = (r_state == S_RESP);
        w_accept     = i_req_valid && w_open && !i_ld_valid;
        w_ld_we      = i_ld_valid && w_open && w_ld_hit;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = ZERO_LAT ? S_RESP : S_WAIT;
                    w_enter_resp = ZERO_LAT;
                end
            end
            S_WAIT: begin
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                // flush wins over a same-cycle resp_ready; either way we go back to IDLE
                if (i_flush || i_resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_pend_err <= 1'b0;
            r_inst     <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx      <= w_req_idx;
                r_pend_err <= w_req_err;
                r_cnt      <= CNT_INIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Zero-latency fetches bypass the latched index and read straight from the request.
            if (w_enter_resp) begin
                if (r_state == S_IDLE) begin
                    r_err  <= w_req_err;
                    r_inst <= w_req_err ? NOP_INST : r_mem[w_req_idx];
                end else begin
                    r_err  <= r_pend_err;
                    r_inst <= r_pend_err ? NOP_INST : r_mem[r_idx];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_ld_we) begin
            r_mem[w_ld_idx] <= i_ld_data;
        end
    end

    assign o_resp_inst = r_inst;
    assign o_resp_err  = r_err;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: three instances (LATENCY 1, 3, 0) share one clock/reset;
// stimulus pushes expected responses, a negedge monitor pops and compares on each handshake.
module tb_imem_responder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [31:0] req_addr   [3];
    logic        flush      [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_inst  [3];
    logic        resp_err   [3];
    logic        ld_valid   [3];
    logic        ld_ready   [3];
    logic [31:0] ld_addr    [3];
    logic [31:0] ld_data    [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imem_responder #(
            .DEPTH    (DEPTH),
            .LATENCY  ((g == 0) ? 1 : (g == 1) ? 3 : 0),
            .BASE_ADDR(32'h0000_0000),
            .NOP_INST (32'h0000_0013)
        ) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_req_valid (req_valid[g]),
            .o_req_ready (req_ready[g]),
            .i_req_addr  (req_addr[g]),
            .i_flush     (flush[g]),
            .o_resp_valid(resp_valid[g]),
            .i_resp_ready(resp_ready[g]),
            .o_resp_inst (resp_inst[g]),
            .o_resp_err  (resp_err[g]),
            .i_ld_valid  (ld_valid[g]),
            .o_ld_ready  (ld_ready[g]),
            .i_ld_addr   (ld_addr[g]),
            .i_ld_data   (ld_data[g])
        );
    end

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 0;
    endfunction

    task automatic check32(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h", name, k, act, exp);
        end
    endtask

    task automatic check1(string name, int k, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %b expected %b", name, k, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rst_n && resp_valid[k] && resp_ready[k] && !flush[k]) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp dut%0d: got inst 0x%08h, expected no response", k, resp_inst[k]);
                end else begin
                    e = sb_q.pop_front();
                    check32("resp_inst", k, resp_inst[k], e.inst);
                    check1("resp_err", k, resp_err[k], e.err);
                end
            end
        end
    end

    task automatic do_load(int k, logic [31:0] a, logic [31:0] d);
        ld_valid[k] = 1'b1;
        ld_addr[k]  = a;
        ld_data[k]  = d;
        #1;
        check1("ld_ready", k, ld_ready[k], 1'b1);
        tick();
        ld_valid[k] = 1'b0;
    endtask

    // Issue one fetch, verify accept-to-valid latency, optional backpressure, and return to IDLE.
    task automatic do_fetch(int k, logic [31:0] a, logic [31:0] ei, logic ee, int hold);
        int   n;
        int   lat;
        exp_t e;
        req_valid[k]  = 1'b1;
        req_addr[k]   = a;
        resp_ready[k] = (hold == 0);
        #1;
        n = 0;
        while (!req_ready[k] && n < 20) begin
            tick();
            n++;
        end
        check1("req_ready_accept", k, req_ready[k], 1'b1);
        e.inst = ei;
        e.err  = ee;
        sb_q.push_back(e);
        tick();
        req_valid[k] = 1'b0;
        lat = 1;
        while (!resp_valid[k] && lat < 30) begin
            tick();
            lat++;
        end
        check32("latency", k, 32'(lat), 32'(1 + lat_of(k)));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                check1("hold_valid", k, resp_valid[k], 1'b1);
                check32("hold_inst", k, resp_inst[k], ei);
                check1("hold_req_ready", k, req_ready[k], 1'b0);
                tick();
            end
            resp_ready[k] = 1'b1;
            #1;
        end
        tick();
        check1("post_valid", k, resp_valid[k], 1'b0);
        check1("post_req_ready", k, req_ready[k], 1'b1);
        resp_ready[k] = 1'b0;
    endtask

    initial begin
        int  n;
        logic seen;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k]  = 1'b0;
            req_addr[k]   = 32'd0;
            flush[k]      = 1'b0;
            resp_ready[k] = 1'b0;
            ld_valid[k]   = 1'b0;
            ld_addr[k]    = 32'd0;
            ld_data[k]    = 32'd0;
        end
        #12;
        check1("rst_req_ready", 0, req_ready[0], 1'b0);
        check1("rst_ld_ready", 0, ld_ready[0], 1'b0);
        check1("rst_resp_valid", 0, resp_valid[0], 1'b0);
        check32("rst_resp_inst", 0, resp_inst[0], 32'd0);
        check1("rst_resp_err", 0, resp_err[0], 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        check1("idle_req_ready", 0, req_ready[0], 1'b1);
        check1("idle_ld_ready", 0, ld_ready[0], 1'b1);

        // load then fetch, backpressure, error fetches on the LATENCY=1 instance
        do_load(0, 32'h0, 32'h0050_0093);
        do_load(0, 32'h4, 32'h0010_8113);
        do_fetch(0, 32'h4, 32'h0010_8113, 1'b0, 0);
        do_fetch(0, 32'h0, 32'h0050_0093, 1'b0, 5);
        do_fetch(0, 32'h2, 32'h0000_0013, 1'b1, 0);
        do_fetch(0, 32'(4 * DEPTH), 32'h0000_0013, 1'b1, 0);
        do_fetch(0, 32'h0, 32'h0050_0093, 1'b0, 0);
        do_fetch(0, 32'h4, 32'h0010_8113, 1'b0, 0);

        // load and fetch in the same cycle: load wins, fetch sees the new word next cycle
        ld_valid[0]  = 1'b1;
        ld_addr[0]   = 32'h8;
        ld_data[0]   = 32'hDEAD_BEEF;
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h8;
        #1;
        check1("prio_req_ready", 0, req_ready[0], 1'b0);
        check1("prio_ld_ready", 0, ld_ready[0], 1'b1);
        tick();
        ld_valid[0] = 1'b0;
        #1;
        check1("prio_next_req_ready", 0, req_ready[0], 1'b1);
        do_fetch(0, 32'h8, 32'hDEAD_BEEF, 1'b0, 0);

        // LATENCY=3 instance: normal, reset during WAIT, flush in WAIT, flush in RESP
        do_load(1, 32'hC, 32'h1234_5678);
        do_fetch(1, 32'hC, 32'h1234_5678, 1'b0, 0);

        req_valid[1]  = 1'b1;
        req_addr[1]   = 32'hC;
        resp_ready[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check1("rstwait_valid", 1, resp_valid[1], 1'b0);
        check1("rstwait_req_ready", 1, req_ready[1], 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= resp_valid[1];
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen |= resp_valid[1];
        end
        check1("rstwait_no_resp", 1, seen, 1'b0);
        resp_ready[1] = 1'b0;
        do_fetch(1, 32'hC, 32'h1234_5678, 1'b0, 0);
        do_fetch(0, 32'h4, 32'h0010_8113, 1'b0, 0);

        req_valid[1]  = 1'b1;
        req_addr[1]   = 32'hC;
        resp_ready[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        flush[1]     = 1'b1;
        #1;
        check1("flushwait_ready", 1, req_ready[1], 1'b0);
        tick();
        flush[1] = 1'b0;
        #1;
        check1("flushwait_idle", 1, req_ready[1], 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= resp_valid[1];
            tick();
        end
        check1("flushwait_no_resp", 1, seen, 1'b0);

        req_valid[1]  = 1'b1;
        req_addr[1]   = 32'hC;
        resp_ready[1] = 1'b0;
        tick();
        req_valid[1] = 1'b0;
        n = 0;
        while (!resp_valid[1] && n < 30) begin
            tick();
            n++;
        end
        check1("flushresp_valid", 1, resp_valid[1], 1'b1);
        flush[1]      = 1'b1;
        resp_ready[1] = 1'b1;
        tick();
        flush[1]      = 1'b0;
        resp_ready[1] = 1'b0;
        #1;
        check1("flushresp_dropped", 1, resp_valid[1], 1'b0);
        check1("flushresp_idle", 1, req_ready[1], 1'b1);

        // LATENCY=0 instance: single fetch, then back-to-back every two cycles
        do_load(2, 32'h0, 32'h0050_0093);
        do_load(2, 32'h4, 32'h0010_8113);
        do_fetch(2, 32'h0, 32'h0050_0093, 1'b0, 0);
        req_valid[2]  = 1'b1;
        req_addr[2]   = 32'h0;
        resp_ready[2] = 1'b1;
        #1;
        check1("b2b_accept0", 2, req_ready[2], 1'b1);
        sb_q.push_back({32'h0050_0093, 1'b0});
        tick();
        req_addr[2] = 32'h4;
        #1;
        check1("b2b_valid0", 2, resp_valid[2], 1'b1);
        check1("b2b_busy", 2, req_ready[2], 1'b0);
        tick();
        check1("b2b_accept1", 2, req_ready[2], 1'b1);
        sb_q.push_back({32'h0010_8113, 1'b0});
        tick();
        req_valid[2] = 1'b0;
        check1("b2b_valid1", 2, resp_valid[2], 1'b1);
        tick();
        resp_ready[2] = 1'b0;
        check1("b2b_done", 2, resp_valid[2], 1'b0);

        repeat (3) tick();
        check32("sb_empty", 0, 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the fetch stage. It accepts word fetch requests from the PC/fetch logic over a valid/ready handshake and returns the instruction after a programmable number of wait states. It supports a pipeline flush that cancels an in-flight fetch on a redirect (`pc_sel`). A separate load port writes program words into the array for boot/testbench loading.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words in the array; power of two.
- `LATENCY`, 1: wait states between request accept and response; range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `NOP_INST`, 32'h0000_0013: instruction returned on an error response.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: fetch request valid.
- `req_ready` out 1: responder can accept a fetch.
- `req_addr` in 32: fetch byte address (PC).
- `flush` in 1: cancel any pending fetch (redirect).
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: fetch stage consumes the response.
- `resp_inst` out 32: fetched instruction.
- `resp_err` out 1: misaligned or out-of-range fetch.
- `ld_valid` in 1: load-word write valid.
- `ld_ready` out 1: load write can be accepted.
- `ld_addr` in 32: load byte address; bits [1:0] ignored.
- `ld_data` in 32: word to write.

## Operation
- States: IDLE, WAIT, RESP. Single outstanding fetch.
- `ld_ready` = IDLE & !flush.
- `req_ready` = IDLE & !flush & !ld_valid. Load has priority over fetch in the same cycle.
- Load accept (`ld_valid & ld_ready`): the word at index (`ld_addr`-`BASE_ADDR`)>>2 is written at that edge. Out-of-range writes are dropped silently with no state change.
- Fetch accept (`req_valid & req_ready`): the address is latched.
  - Error when `req_addr[1:0]`!=0, or `req_addr` < `BASE_ADDR`, or `req_addr` >= `BASE_ADDR`+4*`DEPTH`.
  - The index uses a 32-bit subtraction and then >>2; no wrap-around into range.
- Transitions out of IDLE on fetch accept:
  - `LATENCY`=0: go to RESP.
  - Otherwise: go to WAIT and load the wait counter with `LATENCY`-1.
- WAIT:
  - Counter decrements each cycle; at 0, go to RESP.
  - `flush` returns to IDLE; no response is produced.
- RESP:
  - `resp_valid`=1.
  - `resp_inst` = array word, or `NOP_INST` when `resp_err`=1.
  - Outputs are held stable until `resp_ready`; the handshake returns to IDLE.
  - `flush` in RESP drops the response and returns to IDLE, even if `resp_ready`=1 in the same cycle. Flush wins, so that response is not consumed.
- Array read data is sampled on entry to RESP. A load to the same word cannot occur mid-fetch because loads are IDLE-only.
- Array contents are not affected by reset. Reading a never-written in-range word returns undefined data.

## Timing
- Reset (asynchronous):
  - State IDLE, counter 0, latched address 0.
  - `resp_valid`=0, `resp_inst`=0, `resp_err`=0.
  - `req_ready` and `ld_ready` are forced 0 while `rst_n`=0.
- Reset asserted mid-fetch drops the fetch immediately. After deassertion the block is in IDLE.
- Fetch latency: accept edge at cycle T → `resp_valid` high in cycle T+1+`LATENCY`.
- Throughput: one fetch per 2+`LATENCY` cycles when `resp_ready`=1. No new accept in RESP.
- Load throughput: one word per cycle while `ld_valid`=1 in IDLE.
- `flush` is combinational into `req_ready`/`ld_ready`; registered effect at the next edge.

## Test plan
- Load, then fetch:
  - Stimulus: `LATENCY`=1; load words 0x00500093 @0x0 and 0x00108113 @0x4; fetch 0x4 with `resp_ready`=1.
  - Required: `resp_valid` 2 cycles after accept, `resp_inst`=0x00108113, `resp_err`=0; then back in IDLE with `req_ready`=1.
- Backpressure:
  - Stimulus: fetch 0x0; hold `resp_ready`=0 for 5 cycles.
  - Required: `resp_valid`=1 and `resp_inst`=0x00500093 stable the whole time; `req_ready`=0; one handshake when `resp_ready` rises.
- Errors:
  - Stimulus: fetch 0x2, then 4*`DEPTH`.
  - Required: `resp_err`=1 and `resp_inst`=0x00000013 for both; array unchanged.
- Flush:
  - Stimulus: `LATENCY`=3; flush one cycle after accept; separately, flush in RESP with `resp_ready`=1.
  - Required: no `resp_valid` pulse in the first case, and the response is dropped in the second; IDLE the next cycle in both.
- Priority and reset:
  - Stimulus: `ld_valid` and `req_valid` together in IDLE.
  - Required: load written, `req_ready`=0, fetch accepted the next cycle.
  - Stimulus: `rst_n` pulsed low during WAIT.
  - Required: `resp_valid`=0 immediately; previously loaded data still readable after reset.
- Zero latency:
  - Stimulus: `LATENCY`=0, fetch 0x0.
  - Required: `resp_valid` in the cycle after accept; back-to-back fetches every 2 cycles.
